// File: rtl/lstm_gate_postproc.sv
// rtl/lstm_gate_postproc.sv - LSTM gate back-end: Z_x/Z_h pairing, round/saturate, bias add, hard activation
module lstm_gate_postproc #(
  parameter int DATA_W   = 16,
  parameter int FRAC     = 10,
  parameter int ACC_W    = 32,
  parameter int ACC_FRAC = 20,
  parameter int N_ELEM   = 100,
  parameter int XF_DEPTH = 8,
  parameter int BADDR_W  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               cell_done,
  input  logic               x_valid,
  input  logic [ACC_W-1:0]   x_data,
  output logic               x_full,
  input  logic               h_valid,
  input  logic [ACC_W-1:0]   h_data,
  output logic               h_ready,
  output logic               bias_rd_en,
  output logic [BADDR_W-1:0] bias_addr,
  input  logic [DATA_W-1:0]  bias_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               done,
  output logic               err_ovf
);
  localparam int SH   = ACC_FRAC - FRAC;
  localparam int XA_W = $clog2(XF_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ACC_W:0]    RND    = (ACC_W+1)'(1) << (SH-1);
  localparam logic [ACC_W:0]    R_MAX  = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W:0]    R_MIN  = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] D_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] D_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE    = DATA_W'(1) << FRAC;
  localparam logic [DATA_W-1:0] NEG_ONE = -ONE;
  localparam logic [DATA_W:0]   ONE_W  = (DATA_W+1)'(1) << FRAC;
  localparam logic [DATA_W:0]   HALF_W = (DATA_W+1)'(1) << (FRAC-1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         mode_q;
  logic [BADDR_W-1:0] cnt_q;
  logic [ACC_W-1:0]   xf_mem_q [XF_DEPTH];
  logic [XA_W:0]      wr_ptr_q, rd_ptr_q;
  logic               err_q;
  logic               s1_v_q, s2_v_q, out_v_q;
  logic [ACC_W-1:0]   s1_sum_q;
  logic [DATA_W-1:0]  r_q, b_q, out_q;

  logic               x_empty, push, adv, accept;
  logic [ACC_W-1:0]   x_head;
  logic [ACC_W:0]     r_ext, r_full;
  logic [DATA_W-1:0]  r_sat, s_sat, act;
  logic [DATA_W:0]    sb, sg_sh, sg;

  assign x_empty    = wr_ptr_q == rd_ptr_q;
  assign x_full     = (wr_ptr_q[XA_W] != rd_ptr_q[XA_W]) &&
                      (wr_ptr_q[XA_W-1:0] == rd_ptr_q[XA_W-1:0]);
  assign x_head     = xf_mem_q[rd_ptr_q[XA_W-1:0]];
  assign adv        = !out_v_q || out_ready;
  // cell_done withholds acceptance so no Z_h is silently lost during the clear
  assign h_ready    = (state_q == S_RUN) && !x_empty && adv && !cell_done;
  assign accept     = h_ready && h_valid;
  assign push       = x_valid && !x_full && !cell_done;
  assign bias_rd_en = accept;
  assign bias_addr  = cnt_q;
  assign out_valid  = out_v_q;
  assign out_data   = out_q;
  assign done       = state_q == S_DONE;
  assign err_ovf    = err_q;

  assign r_ext  = {s1_sum_q[ACC_W-1], s1_sum_q} + RND;
  assign r_full = $signed(r_ext) >>> SH;

  always_comb begin
    r_sat = r_full[DATA_W-1:0];
    if ($signed(r_full) > $signed(R_MAX)) r_sat = D_MAX;
    else if ($signed(r_full) < $signed(R_MIN)) r_sat = D_MIN;
  end

  assign sb = {r_q[DATA_W-1], r_q} + {b_q[DATA_W-1], b_q};

  always_comb begin
    s_sat = sb[DATA_W-1:0];
    if (sb[DATA_W] != sb[DATA_W-1]) s_sat = sb[DATA_W] ? D_MIN : D_MAX;
    sg_sh = $signed({s_sat[DATA_W-1], s_sat}) >>> 2;
    sg    = sg_sh + HALF_W;
    case (mode_q)
      2'd0: begin
        if (sg[DATA_W]) act = '0;
        else if (sg > ONE_W) act = ONE;
        else act = sg[DATA_W-1:0];
      end
      2'd1: begin
        if ($signed(s_sat) > $signed(ONE)) act = ONE;
        else if ($signed(s_sat) < $signed(NEG_ONE)) act = NEG_ONE;
        else act = s_sat;
      end
      default: act = s_sat;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && cnt_q == BADDR_W'(N_ELEM-1)) state_d = S_DRAIN;
      // leave once the final result is being taken this cycle
      S_DRAIN: if (!s1_v_q && !s2_v_q && (!out_v_q || out_ready)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) xf_mem_q[wr_ptr_q[XA_W-1:0]] <= x_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      out_v_q  <= 1'b0;
      s1_sum_q <= '0;
      r_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
    end else if (cell_done) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (accept) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (x_valid && x_full) err_q <= 1'b1;
      if (state_q == S_IDLE && start) begin
        cnt_q  <= '0;
        mode_q <= mode;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (adv) begin
        s1_v_q  <= accept;
        s2_v_q  <= s1_v_q;
        out_v_q <= s2_v_q;
        if (accept) s1_sum_q <= x_head + h_data;
        if (s1_v_q) begin
          r_q <= r_sat;
          b_q <= bias_data;
        end
        if (s2_v_q) out_q <= act;
      end
    end
  end
endmodule

// File: tb/tb_lstm_gate_postproc.sv
// tb/tb_lstm_gate_postproc.sv - randomized self-checking bench for lstm_gate_postproc
module tb_lstm_gate_postproc;
  localparam int N  = 100;
  localparam int XF = 8;

  logic        clk = 1'b0;
  logic        rst, start, cell_done, x_valid, h_valid, out_ready;
  logic [1:0]  mode;
  logic [31:0] x_data, h_data;
  logic        x_full, h_ready, bias_rd_en, out_valid, done, err_ovf;
  logic [6:0]  bias_addr;
  logic [15:0] bias_data = 16'h0;
  logic [15:0] out_data;

  logic [15:0] bias_mem [128];
  logic [31:0] xv [N];
  logic [31:0] hv [N];
  bit          dir_chk [N];
  logic [15:0] dir_exp [N];
  int n_vec = 0;
  int n_err = 0;

  lstm_gate_postproc #(.DATA_W(16), .FRAC(10), .ACC_W(32), .ACC_FRAC(20),
                       .N_ELEM(N), .XF_DEPTH(XF), .BADDR_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cell_done(cell_done),
    .x_valid(x_valid), .x_data(x_data), .x_full(x_full),
    .h_valid(h_valid), .h_data(h_data), .h_ready(h_ready),
    .bias_rd_en(bias_rd_en), .bias_addr(bias_addr), .bias_data(bias_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .err_ovf(err_ovf));

  always #5 clk = ~clk;

  always @(posedge clk) if (bias_rd_en) bias_data <= bias_mem[bias_addr];

  // Reference: Q11.20 sum wraps at 32 bits, round-half-up to Q5.10, saturate, add bias, activate
  function automatic logic [15:0] ref_out(input logic [31:0] x, input logic [31:0] h,
                                          input logic [15:0] b, input logic [1:0] m);
    logic [31:0] w;
    longint sum, r, s, y;
    w = x + h;
    sum = longint'($signed(w));
    r = (sum + 512) >>> 10;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    s = r + longint'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    case (m)
      2'd0: begin
        y = (s >>> 2) + 512;
        if (y < 0) y = 0;
        if (y > 1024) y = 1024;
      end
      2'd1: begin
        y = s;
        if (y > 1024) y = 1024;
        if (y < -1024) y = -1024;
      end
      default: y = s;
    endcase
    return y[15:0];
  endfunction

  function automatic logic [31:0] rnd_acc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) == 0) return r;
    return {{8{r[23]}}, r[23:0]};
  endfunction

  task automatic prep_random();
    logic [15:0] b;
    for (int i = 0; i < N; i++) begin
      xv[i] = rnd_acc();
      hv[i] = rnd_acc();
      dir_chk[i] = 1'b0;
      dir_exp[i] = 16'h0;
    end
    for (int i = 0; i < 128; i++) begin
      b = 16'($urandom);
      bias_mem[i] = ($urandom_range(7) == 0) ? b : {{4{b[11]}}, b[11:0]};
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; cell_done = 1'b0; x_valid = 1'b0; h_valid = 1'b0; out_ready = 1'b1;
    x_data = 32'h0; h_data = 32'h0;
  endtask

  // abort_kind: 0 = full pass, 1 = cell_done at abort_at, 2 = rst once out_valid after abort_at
  task automatic run_pass(input logic [1:0] m, input int stall_pct, input int hold_at,
                          input int abort_kind, input int abort_at);
    logic [31:0] xq [$];
    logic [15:0] eq [$];
    logic [15:0] exp_v, prev_data;
    int pushed = 0, acc = 0, got = 0, t_acc = -1, t_out = -1, last_hs = -10, hold_left = 0;
    bit stall_prev = 0, finished = 0, held = 0;
    start = 1'b1; mode = m;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (stall_prev) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_err++;
          $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, prev_data);
        end
      end
      if (done) begin
        n_vec++;
        if (got != N || acc != N || cyc != last_hs + 1) begin
          n_err++;
          $display("FAIL done_timing: outputs=%0d accepts=%0d cyc=%0d last_hs=%0d required %0d/%0d/last_hs+1", got, acc, cyc, last_hs, N, N);
        end
        finished = 1;
        break;
      end
      if (abort_kind == 1 && acc >= abort_at) begin
        cell_done = 1'b1; x_valid = 1'b1; x_data = rnd_acc(); h_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        idle_inputs();
        #1;
        n_vec++;
        if ({out_valid, out_data, done, err_ovf, x_full, bias_addr, bias_rd_en, h_ready} !== '0) begin
          n_err++;
          $display("FAIL clear_state: ov=%b od=%h done=%b err=%b full=%b addr=%0d rd=%b hr=%b required all 0",
                   out_valid, out_data, done, err_ovf, x_full, bias_addr, bias_rd_en, h_ready);
        end
        return;
      end
      if (abort_kind == 2 && acc >= abort_at && out_valid) begin
        idle_inputs();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, out_data, done, err_ovf, x_full, bias_addr, bias_rd_en, h_ready} !== '0) begin
          n_err++;
          $display("FAIL async_reset: ov=%b od=%h done=%b err=%b full=%b addr=%0d rd=%b hr=%b required all 0",
                   out_valid, out_data, done, err_ovf, x_full, bias_addr, bias_rd_en, h_ready);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        return;
      end
      x_valid = (cyc > 0) && pushed < N && xq.size() < XF && $urandom_range(3) != 0;
      x_data  = (pushed < N) ? xv[pushed] : 32'h0;
      h_valid = (cyc == 0) || $urandom_range(3) != 0;
      h_data  = (acc < N) ? hv[acc] : 32'h0;
      if (got == hold_at && !held) begin
        held = 1;
        hold_left = 5;
      end
      out_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(99) >= stall_pct);
      if (hold_left > 0) hold_left--;
      #1;
      n_vec++;
      if (x_full !== (xq.size() == XF)) begin
        n_err++;
        $display("FAIL x_full: got %b required %b", x_full, xq.size() == XF);
      end
      if (cyc == 0) begin
        n_vec++;
        if (h_ready !== 1'b0) begin
          n_err++;
          $display("FAIL empty_fifo_at_start: h_ready=%b required 0", h_ready);
        end
      end
      if (x_valid && !x_full) begin
        xq.push_back(x_data);
        pushed++;
      end
      if (out_valid && !out_ready) begin
        n_vec++;
        if (h_ready !== 1'b0) begin
          n_err++;
          $display("FAIL stall_h_ready: got %b required 0", h_ready);
        end
      end
      if (h_valid && h_ready) begin
        n_vec++;
        if (bias_rd_en !== 1'b1 || bias_addr !== 7'(acc) || xq.size() == 0) begin
          n_err++;
          $display("FAIL bias_addr: rd_en=%b addr=%0d fifo=%0d required rd_en=1 addr=%0d fifo>0", bias_rd_en, bias_addr, xq.size(), acc);
        end
        if (xq.size() > 0) eq.push_back(ref_out(xq.pop_front(), h_data, bias_mem[acc], m));
        if (t_acc < 0) t_acc = cyc;
        acc++;
      end
      if (out_valid && t_out < 0) begin
        t_out = cyc;
        n_vec++;
        if (t_out - t_acc != 3) begin
          n_err++;
          $display("FAIL latency: got %0d cycles required 3", t_out - t_acc);
        end
      end
      if (out_valid && out_ready) begin
        exp_v = (eq.size() > 0) ? eq.pop_front() : 16'hxxxx;
        n_vec++;
        if (out_data !== exp_v) begin
          n_err++;
          $display("FAIL out_data[%0d]: got %h required %h", got, out_data, exp_v);
        end
        if (got < N && dir_chk[got]) begin
          n_vec++;
          if (out_data !== dir_exp[got]) begin
            n_err++;
            $display("FAIL directed[%0d]: got %h required %h", got, out_data, dir_exp[got]);
          end
        end
        got++;
        last_hs = cyc;
      end
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
      @(posedge clk); @(negedge clk);
    end
    idle_inputs();
    if (abort_kind == 0) begin
      n_vec++;
      if (!finished) begin
        n_err++;
        $display("FAIL pass_timeout: outputs=%0d required %0d with done", got, N);
      end
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || h_ready !== 1'b0) begin
        n_err++;
        $display("FAIL done_pulse: done=%b h_ready=%b required 0 0", done, h_ready);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({out_valid, out_data, done, err_ovf, x_full, bias_addr, bias_rd_en, h_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_state: ov=%b od=%h done=%b err=%b full=%b addr=%0d rd=%b hr=%b required all 0",
               out_valid, out_data, done, err_ovf, x_full, bias_addr, bias_rd_en, h_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_basic_path();
    prep_random();
    xv[0] = 32'h0010_0000; hv[0] = 32'h0008_0000; bias_mem[0] = 16'h0000;
    dir_chk[0] = 1'b1; dir_exp[0] = 16'h0380;
    run_pass(2'd0, 0, -1, 0, 0);
  endtask

  task automatic test_saturation_rounding();
    prep_random();
    xv[0] = 32'h3FF0_0000; hv[0] = 32'h3FF0_0000; bias_mem[0] = 16'h0;
    dir_chk[0] = 1'b1; dir_exp[0] = 16'h7FFF;
    xv[1] = 32'h0000_0200; hv[1] = 32'h0; bias_mem[1] = 16'h0;
    dir_chk[1] = 1'b1; dir_exp[1] = 16'h0001;
    xv[2] = 32'h0000_01FF; hv[2] = 32'h0; bias_mem[2] = 16'h0;
    dir_chk[2] = 1'b1; dir_exp[2] = 16'h0000;
    run_pass(2'd2, 10, -1, 0, 0);
    prep_random();
    xv[0] = 32'h0030_0000; hv[0] = 32'h0; bias_mem[0] = 16'h0;
    dir_chk[0] = 1'b1; dir_exp[0] = 16'h0400;
    xv[1] = 32'hFFD0_0000; hv[1] = 32'h0; bias_mem[1] = 16'h0;
    dir_chk[1] = 1'b1; dir_exp[1] = 16'hFC00;
    run_pass(2'd1, 10, -1, 0, 0);
  endtask

  task automatic test_back_pressure();
    prep_random();
    run_pass(2'd3, 50, 40, 0, 0);
  endtask

  task automatic test_fifo_boundary();
    int nacc = 0;
    for (int i = 0; i < 9; i++) begin
      x_valid = 1'b1; x_data = rnd_acc();
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (x_full !== (i >= 7) || err_ovf !== (i == 8)) begin
        n_err++;
        $display("FAIL fifo_write[%0d]: full=%b err=%b required %b %b", i, x_full, err_ovf, i >= 7, i == 8);
      end
    end
    x_valid = 1'b0;
    start = 1'b1; mode = 2'd2;
    @(posedge clk); @(negedge clk);
    start = 1'b0; h_valid = 1'b1; out_ready = 1'b1;
    repeat (20) begin
      #1;
      if (h_ready) nacc++;
      @(posedge clk); @(negedge clk);
    end
    h_valid = 1'b0;
    n_vec++;
    if (nacc != 8 || err_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL fifo_pops: pops=%0d err=%b required 8 1", nacc, err_ovf);
    end
    cell_done = 1'b1;
    @(posedge clk); @(negedge clk);
    cell_done = 1'b0;
    #1;
    n_vec++;
    if ({err_ovf, x_full, out_valid, done, h_ready} !== '0) begin
      n_err++;
      $display("FAIL fifo_clear: err=%b full=%b ov=%b done=%b hr=%b required all 0", err_ovf, x_full, out_valid, done, h_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_pass_clear();
    prep_random();
    run_pass(2'd1, 20, -1, 1, 50);
    prep_random();
    run_pass(2'd0, 20, -1, 0, 0);
  endtask

  task automatic test_reset_mid_pass();
    prep_random();
    run_pass(2'd2, 30, -1, 2, 30);
    prep_random();
    run_pass(2'd1, 30, -1, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    mode = 2'd0;
    idle_inputs();
    prep_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_basic_path();
    test_saturation_rounding();
    test_back_pressure();
    test_fifo_boundary();
    test_mid_pass_clear();
    test_reset_mid_pass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
